// File: rtl/alu_mul_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer_pkg
//   Shared definitions for the EX-stage ALU/multiply sequencer:
//     - DEFAULT_WIDTH : default datapath width, must match the ALU
//     - EXE_*         : 4-bit EX command codes understood by the ALU
//     - seq_state_e   : sequencer state encoding
//     - alu_owner_e   : which side currently drives the ALU input ports
// -----------------------------------------------------------------------------
package alu_mul_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // EX command codes. Only EXE_ADD is issued by the sequencer itself; the
    // rest are carried through untouched from the pipeline.
    localparam logic [3:0] EXE_ADD  = 4'b0000;
    localparam logic [3:0] EXE_SUB  = 4'b0001;
    localparam logic [3:0] EXE_AND  = 4'b0010;
    localparam logic [3:0] EXE_OR   = 4'b0011;
    localparam logic [3:0] EXE_XOR  = 4'b0100;
    localparam logic [3:0] EXE_SLL  = 4'b0101;
    localparam logic [3:0] EXE_SRL  = 4'b0110;
    localparam logic [3:0] EXE_SRA  = 4'b0111;
    localparam logic [3:0] EXE_SLT  = 4'b1000;
    localparam logic [3:0] EXE_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    typedef enum logic {
        OWNER_PIPE = 1'b0,
        OWNER_SEQ  = 1'b1
    } alu_owner_e;

endpackage

// File: rtl/alu_mul_sequencer_port_mux.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer_port_mux
//   Combinational owner-select of the ALU command/operand ports.
//   Ports:
//     i_owner                        : OWNER_PIPE or OWNER_SEQ
//     i_pipe_cmd/val1/val2           : pipeline request
//     i_seq_cmd/val1/val2            : sequencer request
//     o_alu_cmd/val1/val2            : ports driven to the ALU
// -----------------------------------------------------------------------------
module alu_mul_sequencer_port_mux
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  alu_owner_e        i_owner,
    input  logic [3:0]        i_pipe_cmd,
    input  logic [WIDTH-1:0]  i_pipe_val1,
    input  logic [WIDTH-1:0]  i_pipe_val2,
    input  logic [3:0]        i_seq_cmd,
    input  logic [WIDTH-1:0]  i_seq_val1,
    input  logic [WIDTH-1:0]  i_seq_val2,
    output logic [3:0]        o_alu_cmd,
    output logic [WIDTH-1:0]  o_alu_val1,
    output logic [WIDTH-1:0]  o_alu_val2
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves it unassigned, which would infer a latch.
        o_alu_cmd  = i_pipe_cmd;
        o_alu_val1 = i_pipe_val1;
        o_alu_val2 = i_pipe_val2;
        if (i_owner == OWNER_SEQ) begin
            o_alu_cmd  = i_seq_cmd;
            o_alu_val1 = i_seq_val1;
            o_alu_val2 = i_seq_val2;
        end
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer
//   Shares the EX-stage ALU between the pipeline and an iterative
//   shift-and-add multiplier. Idle: pipeline requests pass straight through.
//   On a multiply request the block owns the ALU, issues one ADD per
//   multiplier bit and stalls the pipeline until the low-word product is
//   ready (one-cycle o_mul_done pulse).
//   Ports:
//     i_clk, i_rst                  : clock, asynchronous active-low reset
//     i_pipe_cmd/val1/val2          : EX command and operands from the pipeline
//     i_mul_start, i_mul_a, i_mul_b : multiply request, multiplicand, multiplier
//     i_alu_out                     : result from the external ALU
//     o_alu_cmd/val1/val2           : command and operands driven to the ALU
//     o_stall                       : freeze upstream pipeline stages
//     o_busy                        : sequencer owns the ALU
//     o_mul_done, o_mul_result      : result-valid pulse, low word of a*b
// -----------------------------------------------------------------------------
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_pipe_cmd,
    input  logic [WIDTH-1:0]  i_pipe_val1,
    input  logic [WIDTH-1:0]  i_pipe_val2,
    input  logic              i_mul_start,
    input  logic [WIDTH-1:0]  i_mul_a,
    input  logic [WIDTH-1:0]  i_mul_b,
    input  logic [WIDTH-1:0]  i_alu_out,
    output logic [3:0]        o_alu_cmd,
    output logic [WIDTH-1:0]  o_alu_val1,
    output logic [WIDTH-1:0]  o_alu_val2,
    output logic              o_stall,
    output logic              o_busy,
    output logic              o_mul_done,
    output logic [WIDTH-1:0]  o_mul_result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    seq_state_e        r_state;
    seq_state_e        w_next_state;
    alu_owner_e        w_owner;

    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_mplr;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_mul_result;

    logic              w_start_accept;
    logic [WIDTH-1:0]  w_mplr_next;
    logic [WIDTH-1:0]  w_acc_next;
    logic              w_last_iter;

    // ------------------------------------------------------------------
    // Iteration helpers
    // ------------------------------------------------------------------
    assign w_start_accept = (r_state == ST_IDLE) && i_mul_start;
    assign w_mplr_next    = r_mplr >> 1;
    // The ALU is computing acc + mcand this cycle; keep it only when the
    // current multiplier bit is set.
    assign w_acc_next     = r_mplr[0] ? i_alu_out : r_acc;
    // Early exit looks at the multiplier as it will be after this shift:
    // once no set bits remain, further ADDs cannot change the product.
    assign w_last_iter    = (r_cnt == CNT_W'(WIDTH - 1))
                         || (EARLY_EXIT && (w_mplr_next == '0));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_mul_start) begin
                    w_next_state = (i_mul_b == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_iter) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_owner    = OWNER_PIPE;
        o_stall    = 1'b0;
        o_busy     = 1'b0;
        o_mul_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Hold the requesting instruction in EX while the start is
                // being accepted.
                o_stall = i_mul_start;
            end
            ST_RUN: begin
                w_owner = OWNER_SEQ;
                o_stall = 1'b1;
                o_busy  = 1'b1;
            end
            ST_DONE: begin
                // Stall drops so the pipeline captures o_mul_result now.
                o_busy     = 1'b1;
                o_mul_done = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiplier datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplr       <= '0;
            r_cnt        <= '0;
            r_mul_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_accept) begin
                        r_acc   <= '0;
                        r_mcand <= i_mul_a;
                        r_mplr  <= i_mul_b;
                        r_cnt   <= '0;
                        // A zero multiplier skips RUN entirely.
                        if (i_mul_b == '0) begin
                            r_mul_result <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= w_mplr_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last_iter) begin
                        r_mul_result <= w_acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mul_result = r_mul_result;

    // ------------------------------------------------------------------
    // ALU port ownership
    // ------------------------------------------------------------------
    alu_mul_sequencer_port_mux #(
        .WIDTH (WIDTH)
    ) u_port_mux (
        .i_owner     (w_owner),
        .i_pipe_cmd  (i_pipe_cmd),
        .i_pipe_val1 (i_pipe_val1),
        .i_pipe_val2 (i_pipe_val2),
        .i_seq_cmd   (EXE_ADD),
        .i_seq_val1  (r_acc),
        .i_seq_val2  (r_mcand),
        .o_alu_cmd   (o_alu_cmd),
        .o_alu_val1  (o_alu_val1),
        .o_alu_val2  (o_alu_val2)
    );

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_sequencer
//   Two instances share one stimulus stream: index 0 with EARLY_EXIT=1,
//   index 1 with EARLY_EXIT=0. Each has its own ALU model. A transaction-level
//   model (operands, iteration index, expected product) predicts every output
//   on every falling edge; directed literals pin results and RUN lengths.
// -----------------------------------------------------------------------------
module tb_alu_mul_sequencer;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [3:0]     pipe_cmd = '0;
    logic [W-1:0]   pipe_val1 = '0;
    logic [W-1:0]   pipe_val2 = '0;
    logic           mul_start = 1'b0;
    logic [W-1:0]   mul_a = '0;
    logic [W-1:0]   mul_b = '0;

    logic [3:0]     alu_cmd    [2];
    logic [W-1:0]   alu_val1   [2];
    logic [W-1:0]   alu_val2   [2];
    logic [W-1:0]   alu_out    [2];
    logic           stall      [2];
    logic           busy       [2];
    logic           mul_done   [2];
    logic [W-1:0]   mul_result [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_mul_sequencer #(
            .WIDTH      (W),
            .EARLY_EXIT (g == 0)
        ) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_pipe_cmd   (pipe_cmd),
            .i_pipe_val1  (pipe_val1),
            .i_pipe_val2  (pipe_val2),
            .i_mul_start  (mul_start),
            .i_mul_a      (mul_a),
            .i_mul_b      (mul_b),
            .i_alu_out    (alu_out[g]),
            .o_alu_cmd    (alu_cmd[g]),
            .o_alu_val1   (alu_val1[g]),
            .o_alu_val2   (alu_val2[g]),
            .o_stall      (stall[g]),
            .o_busy       (busy[g]),
            .o_mul_done   (mul_done[g]),
            .o_mul_result (mul_result[g])
        );
        // External ALU: ADD for code 0000, SUB for anything else.
        assign alu_out[g] = (alu_cmd[g] == 4'b0000) ? alu_val1[g] + alu_val2[g]
                                                    : alu_val1[g] - alu_val2[g];
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Number of ADD iterations the multiplier must take for multiplier b.
    function automatic int iterations(input logic [W-1:0] b, input bit early);
        if (b == '0) return 0;
        if (!early) return W;
        for (int i = W - 1; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 0;
    endfunction

    // ---------------------------------------------------------------
    // Transaction-level model
    // ---------------------------------------------------------------
    bit           m_run   [2] = '{1'b0, 1'b0};
    bit           m_done  [2] = '{1'b0, 1'b0};
    int           m_k     [2] = '{0, 0};
    int           m_iters [2] = '{0, 0};
    logic [W-1:0] m_a     [2] = '{'0, '0};
    logic [W-1:0] m_b     [2] = '{'0, '0};
    logic [W-1:0] m_res   [2] = '{'0, '0};
    int           run_cnt [2] = '{0, 0};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i]  <= 1'b0;
                m_done[i] <= 1'b0;
                m_k[i]    <= 0;
                m_res[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_done[i]) begin
                    m_done[i] <= 1'b0;
                end else if (m_run[i]) begin
                    m_k[i] <= m_k[i] + 1;
                    if (m_k[i] + 1 == m_iters[i]) begin
                        m_run[i]  <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_res[i]  <= m_a[i] * m_b[i];
                    end
                end else if (mul_start) begin
                    m_a[i]     <= mul_a;
                    m_b[i]     <= mul_b;
                    m_k[i]     <= 0;
                    m_iters[i] <= iterations(mul_b, i == 0);
                    if (iterations(mul_b, i == 0) == 0) begin
                        m_done[i] <= 1'b1;
                        m_res[i]  <= '0;
                    end else begin
                        m_run[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Compare process: every output of both instances on every falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [W-1:0] mask;
            logic [3:0]   e_cmd;
            logic [W-1:0] e_v1, e_v2;
            mask  = (m_k[i] == 0) ? '0 : ({W{1'b1}} >> (W - m_k[i]));
            e_cmd = pipe_cmd;
            e_v1  = pipe_val1;
            e_v2  = pipe_val2;
            if (m_run[i]) begin
                // Before iteration k the accumulator holds a * (low k bits of b)
                // and the ALU adds the multiplicand shifted by k.
                e_cmd = 4'b0000;
                e_v1  = m_a[i] * (m_b[i] & mask);
                e_v2  = m_a[i] << m_k[i];
            end
            check($sformatf("dut%0d alu_cmd", i),    alu_cmd[i],  e_cmd);
            check($sformatf("dut%0d alu_val1", i),   alu_val1[i], e_v1);
            check($sformatf("dut%0d alu_val2", i),   alu_val2[i], e_v2);
            check($sformatf("dut%0d stall", i),      stall[i],
                  m_run[i] || (!m_done[i] && mul_start));
            check($sformatf("dut%0d busy", i),       busy[i],     m_run[i] || m_done[i]);
            check($sformatf("dut%0d mul_done", i),   mul_done[i], m_done[i]);
            check($sformatf("dut%0d mul_result", i), mul_result[i], m_res[i]);
            if (busy[i] && !mul_done[i]) run_cnt[i]++;
        end
    end

    // ---------------------------------------------------------------
    // Directed stimulus
    // ---------------------------------------------------------------
    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy[0] || busy[1]) && n < 100);
        check("idle within budget", busy[0] | busy[1], 1'b0);
        #1;
    endtask

    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        mul_start  = 1'b1;
        mul_a      = a;
        mul_b      = b;
        run_cnt[0] = 0;
        run_cnt[1] = 0;
        #1;
        check("start stall", stall[0], 1'b1);
        @(posedge clk);
        #1;
        mul_start = 1'b0;
    endtask

    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input int exp_run0, input int exp_run1);
        pulse_start(a, b);
        wait_idle();
        check($sformatf("result %h*%h early", a, b), mul_result[0], exp_res);
        check($sformatf("result %h*%h full", a, b),  mul_result[1], exp_res);
        check($sformatf("run cycles %h early", b),   run_cnt[0], exp_run0);
        check($sformatf("run cycles %h full", b),    run_cnt[1], exp_run1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        pipe_cmd  = 4'b0101;
        pipe_val1 = 32'hDEAD_0001;
        pipe_val2 = 32'h0000_BEEF;
        #1;
        check("reset busy",       busy[0],       1'b0);
        check("reset stall",      stall[0],      1'b0);
        check("reset mul_done",   mul_done[0],   1'b0);
        check("reset mul_result", mul_result[0], 32'h0);
        check("reset alu_cmd",    alu_cmd[0],    4'b0101);
        check("reset alu_val1",   alu_val1[0],   32'hDEAD_0001);
        rst = 1'b1;

        // Idle pass-through
        @(posedge clk);
        #1;
        pipe_cmd  = 4'b0010;
        pipe_val1 = 32'd9;
        pipe_val2 = 32'd4;
        #1;
        check("idle alu_cmd",  alu_cmd[0],  4'b0010);
        check("idle alu_val1", alu_val1[0], 32'd9);
        check("idle alu_val2", alu_val2[0], 32'd4);
        check("idle stall",    stall[0],    1'b0);
        check("idle busy",     busy[0],     1'b0);

        // Multiplies: a, b, low word, RUN cycles (early exit, full length)
        do_mul(32'd3,          32'd5,          32'd15,          3,  32);
        do_mul(32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,   32, 32);
        do_mul(32'h0001_0000,  32'h0001_0000,  32'h0000_0000,   17, 32);
        do_mul(32'h0000_1234,  32'h0,          32'h0,           0,  0);
        do_mul(32'h0000_1235,  32'h8000_0000,  32'h8000_0000,   32, 32);
        do_mul(32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,   3,  32);

        // Start during RUN is ignored
        pulse_start(32'd3, 32'd5);
        @(posedge clk);
        #1;
        mul_start = 1'b1;
        mul_a     = 32'd7;
        mul_b     = 32'd7;
        @(posedge clk);
        #1;
        mul_start = 1'b0;
        wait_idle();
        check("ignored start result", mul_result[0], 32'd15);
        check("ignored start runs",   run_cnt[0],    3);
        do_mul(32'd7, 32'd7, 32'd49, 3, 32);

        // Reset in the second RUN cycle
        pulse_start(32'd6, 32'h0000_00FF);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort busy",       busy[0],       1'b0);
        check("abort stall",      stall[0],      1'b0);
        check("abort mul_done",   mul_done[0],   1'b0);
        check("abort mul_result", mul_result[0], 32'h0);
        check("abort full busy",  busy[1],       1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_mul(32'd2, 32'd3, 32'd6, 2, 32);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that shares the EX-stage ALU between the normal pipeline path and an iterative shift-and-add multiplier.
- Sits between the EX-stage operand/command muxes and the ALU.
- When idle, pipeline ALU requests pass straight through.
- On a multiply request, the block takes ownership of the ALU and sequences one ADD per multiplier bit. It stalls the pipeline until the low-word product is ready.

Parameters:
- WIDTH, 32, operand/result width. Must match the ALU datapath.
- EARLY_EXIT, 1. When 1, iteration stops once the remaining multiplier bits are all zero. When 0, it always runs WIDTH iterations.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pipe_cmd  in  4  EX command from the pipeline.
- pipe_val1  in  WIDTH  pipeline operand 1.
- pipe_val2  in  WIDTH  pipeline operand 2.
- mul_start  in  1  multiply request; sampled only in IDLE.
- mul_a  in  WIDTH  multiplicand; latched on an accepted start.
- mul_b  in  WIDTH  multiplier; latched on an accepted start.
- alu_out  in  WIDTH  ALU result.
- alu_cmd  out  4  command driven to the ALU.
- alu_val1  out  WIDTH  operand 1 driven to the ALU.
- alu_val2  out  WIDTH  operand 2 driven to the ALU.
- stall  out  1  freeze the upstream pipeline stages.
- busy  out  1  sequencer owns the ALU.
- mul_done  out  1  one-cycle pulse; result valid.
- mul_result  out  WIDTH  low WIDTH bits of mul_a*mul_b.

Behaviour:
- Registers:
  - acc, mcand, mplr: WIDTH bits each.
  - cnt: clog2(WIDTH)+1 bits.
  - mul_result: WIDTH bits.
  - state: IDLE / RUN / DONE.
- Reset (rst low, asynchronous):
  - state=IDLE; acc, mcand, mplr, cnt, mul_result = 0.
  - Outputs therefore reset to: mul_done=0, busy=0, stall=0, alu_* = pass-through of pipe_*.
- IDLE:
  - alu_cmd/val1/val2 = pipe_cmd/val1/val2, combinational.
  - stall = mul_start, combinational, so the requesting instruction holds in EX.
  - On mul_start: mcand<=mul_a, mplr<=mul_b, acc<=0, cnt<=0.
  - Next state: if mul_b==0 go to DONE, else RUN.
- RUN (one iteration per cycle):
  - alu_cmd=EXE_ADD (4'b0000), alu_val1=acc, alu_val2=mcand. pipe_* are ignored.
  - If mplr[0]==1, acc<=alu_out; else acc holds.
  - mcand<=mcand<<1; mplr<=mplr>>1 (logical, zero fill); cnt<=cnt+1.
  - All arithmetic is modulo 2^WIDTH; carries out are discarded.
  - Exit to DONE when cnt==WIDTH-1, or, if EARLY_EXIT=1, when mplr>>1 == 0.
  - Iteration count: index of the highest set bit of mul_b, plus 1 (EARLY_EXIT=1); WIDTH (EARLY_EXIT=0).
  - stall=1, busy=1.
- DONE (exactly one cycle):
  - mul_result is registered with the final acc value on entry to DONE, so it is valid during DONE.
  - mul_done=1, busy=1, stall=0 (pipeline captures mul_result this cycle).
  - ALU ports pass through pipe_*.
  - Next state: IDLE unconditionally.
- mul_result holds its value until the next DONE or reset.
- Latency: an accepted start at edge N gives mul_done high in cycle N+1+iterations.
- Boundaries:
  - mul_start in RUN or DONE is ignored; there is no queueing.
  - mul_b==0: zero RUN cycles, result 0, mul_done in the cycle after start.
  - Signed operands yield the correct low word (two's complement).
  - Reset mid-RUN aborts the operation: state=IDLE, no mul_done pulse, mul_result=0.
  - pipe_cmd values other than those passed through are not interpreted by this block.

Decomposition:
- Shared package/defines file: EXE_ADD and the other 4-bit EXE command codes, state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), WIDTH default.
- The ALU stays a separate instance outside this block.
- Natural sub-module: alu_port_mux (combinational owner-select of cmd/val1/val2). Everything else is inline.

Test Plan:
- Idle pass-through: mul_start=0, pipe_cmd=4'b0010, val1=9, val2=4 -> alu_cmd=0010, alu_val1=9, alu_val2=4 same cycle; stall=0, busy=0.
- Small multiply: start with a=3, b=5 -> 3 RUN cycles with alu_cmd=0000, stall=1; mul_done pulses 4 cycles after the start edge; mul_result=15; stall=0 in the DONE cycle.
- Full-length wrap: a=0xFFFFFFFF, b=0xFFFFFFFF -> 32 RUN cycles, mul_result=0x00000001. Also a=0x00010000, b=0x00010000 -> 17 RUN cycles, mul_result=0.
- Zero multiplier: a=0x1234, b=0 -> no RUN, mul_done next cycle, mul_result=0. Also b=0x80000000, EARLY_EXIT=0 -> 32 cycles, result 0x80000000*a low word.
- Ignored start: assert mul_start with a=7, b=7 during RUN of 3*5 -> result still 15, no second operation; a new start after DONE gives 49.
- Reset mid-operation: pull rst low in the 2nd RUN cycle of a=6, b=0xFF -> immediate IDLE, busy=0, stall=0, mul_result=0, no mul_done; the next start a=2, b=3 gives 6.
